// File: rtl/rsa_decrypt_stage.sv
// rsa_decrypt_stage: byte-serial RSA decryption, plaintext = c^D_EXP mod N_MOD.
// Right-to-left square-and-multiply. Each modular product uses an MSB-first
// interleaved shift-add reducer, so there is no wide multiplier or divider.
// Optional feature macro: RSA_DEC_OVERRUN_EN (sticky overrun flag for dropped bytes).
module rsa_decrypt_stage #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned N_MOD     = 143,
  parameter int unsigned D_EXP     = 103
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_err,
  output logic             overrun
);

  localparam int unsigned KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int unsigned JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH:0]     NMod = (WIDTH + 1)'(N_MOD);
  localparam logic [EXP_WIDTH-1:0] DExp = EXP_WIDTH'(D_EXP);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] result_q, base_q;
  logic [WIDTH-1:0] acc_r_q, acc_b_q;
  logic [WIDTH-1:0] acc_r_d, acc_b_d;
  logic [KW-1:0]    k_q;
  logic [JW-1:0]    j_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_err_q;
  logic             last_j, last_k;

  // One reducer step: acc = (2*acc + bit*a) mod N, valid because acc, a < N.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] a,
                                                input logic             b);
    logic [WIDTH:0] t;
    t = {acc, 1'b0};
    if (t >= NMod) t = t - NMod;
    if (b) begin
      t = t + {1'b0, a};
      if (t >= NMod) t = t - NMod;
    end
    return t[WIDTH-1:0];
  endfunction

  // Both products walk the bits of base: R = result*base, B = base*base.
  always_comb begin
    acc_r_d = mod_step(acc_r_q, result_q, base_q[j_q]);
    acc_b_d = mod_step(acc_b_q, base_q, base_q[j_q]);
    last_j  = (j_q == '0);
    last_k  = (k_q == KW'(EXP_WIDTH - 1));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      result_q   <= '0;
      base_q     <= '0;
      acc_r_q    <= '0;
      acc_b_q    <= '0;
      k_q        <= '0;
      j_q        <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            out_data_q <= '0;
            if ({1'b0, in_data} >= NMod) begin
              out_err_q <= 1'b1;
              state_q   <= StDone;
            end else begin
              out_err_q <= 1'b0;
              result_q  <= WIDTH'(1);
              base_q    <= in_data;
              acc_r_q   <= '0;
              acc_b_q   <= '0;
              k_q       <= '0;
              j_q       <= JW'(WIDTH - 1);
              state_q   <= StMul;
            end
          end
        end
        StMul: begin
          if (last_j) begin
            if (DExp[k_q]) result_q <= acc_r_d;
            base_q  <= acc_b_d;
            acc_r_q <= '0;
            acc_b_q <= '0;
            k_q     <= k_q + 1'b1;
            j_q     <= JW'(WIDTH - 1);
            if (last_k) begin
              out_data_q <= DExp[k_q] ? acc_r_d : result_q;
              state_q    <= StDone;
            end
          end else begin
            acc_r_q <= acc_r_d;
            acc_b_q <= acc_b_d;
            j_q     <= j_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

`ifdef RSA_DEC_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: a byte was presented while the stage could not take it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_decrypt_stage.sv
// Self-checking bench for rsa_decrypt_stage (default parameters: N=143, D=103).
module tb_rsa_decrypt_stage;

  localparam int N   = 143;
  localparam int D   = 103;
  localparam int E   = 7;
  localparam int LAT = 8 * 8 + 1;
`ifdef RSA_DEC_OVERRUN_EN
  localparam bit OvrEn = 1'b1;
`else
  localparam bit OvrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       out_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  rsa_decrypt_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_err   (out_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain modular exponentiation by repeated multiply-and-mod.
  function automatic int modpow(input int b, input int e, input int m);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return int'(r);
  endfunction

  // Send one byte, measure latency, check result, then accept after 'hold' cycles.
  task automatic decrypt(input int c, input int hold, input bit early, output int got);
    int  exp_d;
    bit  exp_e;
    int  cyc;
    exp_e = (c >= N);
    exp_d = exp_e ? 0 : modpow(c, D, N);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = 8'(c);
    out_ready = early;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, exp_e ? 1 : LAT);
    check("out_data", out_data, exp_d);
    check("out_err", out_err, exp_e);
    check("in_ready_done", in_ready, 0);
    got = int'(out_data);
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, exp_d);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int cyc;
    bit spurious;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b1;

    // Directed vectors, including modulus boundary and error recovery
    decrypt(12, 0, 0, got);
    check("dec_12", got, 12);
    decrypt(128, 0, 0, got);
    check("dec_128", got, 2);
    decrypt(142, 1, 0, got);
    check("dec_142", got, 142);
    decrypt(0, 0, 0, got);
    check("dec_0", got, 0);
    decrypt(1, 2, 0, got);
    check("dec_1", got, 1);
    decrypt(143, 0, 0, got);
    decrypt(12, 0, 0, got);
    decrypt(255, 3, 0, got);
    decrypt(12, 0, 0, got);
    decrypt(128, 0, 1, got);
    decrypt(143, 0, 1, got);
    check("ovr_clean", overrun, 0);

    // Backpressure in DONE with a dropped byte
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd12;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", cyc, LAT);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 12);
      check("bp_in_ready", in_ready, 0);
      in_valid = (i == 10);
      in_data  = 8'd5;
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("bp_overrun", overrun, OvrEn);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid || !in_ready) spurious = 1'b1;
      @(negedge clk);
    end
    check("dropped_not_processed", spurious, 0);
    check("overrun_sticky", overrun, OvrEn);

    // Asynchronous reset mid-computation
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd12;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_err", out_err, 0);
    check("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b1;
    decrypt(128, 0, 0, got);
    check("post_rst_128", got, 2);

    // Asynchronous reset while holding an error result
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    check("err_hold_err", out_err, 1);
    #2 reset = 1'b0;
    #1;
    check("done_rst_err", out_err, 0);
    check("done_rst_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b1;

    // Random ciphertexts with random consumer behaviour
    for (int i = 0; i < 40; i++) begin
      decrypt(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), got);
    end

    // Loopback: every plaintext encrypted with e=7 must decrypt to itself
    for (int p = 0; p < N; p++) begin
      decrypt(modpow(p, E, N), 0, bit'(p % 2), got);
      check("loopback", got, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
